adc9252_align_ctrl: RTL and testbench

Alignment sequencer for the multi-channel ADC9252 LVDS capture path. After configuration it walks the channels one at a time, issuing single bit-slip pulses until each channel's deserialized frame word shows the FCO pattern stably. It then enables data capture and monitors lock, re-aligning automatically on loss. It sits between the SPI configuration done flag and the per-channel deserializers and data FIFOs.

---
 rtl/adc9252_align_ctrl_if.sv | 33 +++
 rtl/adc9252_align_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_adc9252_align_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc9252_align_ctrl_if.sv
// Handshake/bus bundle between the alignment sequencer and its surroundings:
// start/enable/frame words in, bit-slip pulses and status out.
interface adc9252_align_ctrl_if #(
    parameter int NCH  = 8,
    parameter int CH_W = 3
);
    logic                start;
    logic                clk_en;
    logic [NCH*14-1:0]   frame_word;
    logic [NCH-1:0]      bit_slip;
    logic [NCH-1:0]      ch_aligned;
    logic                capture_en;
    logic                busy;
    logic                done;
    logic                error;
    logic [CH_W-1:0]     fail_ch;
    logic [7:0]          relock_cnt;
    logic [2:0]          state_dbg;

    // Driver side: SPI-done/enable/deserializer source
    modport master (
        output start, clk_en, frame_word,
        input  bit_slip, ch_aligned, capture_en, busy, done, error,
               fail_ch, relock_cnt, state_dbg
    );

    // Sequencer side
    modport slave (
        input  start, clk_en, frame_word,
        output bit_slip, ch_aligned, capture_en, busy, done, error,
               fail_ch, relock_cnt, state_dbg
    );
endinterface

// File: rtl/adc9252_align_ctrl.sv
// ADC9252 LVDS alignment sequencer: aligns each channel to the FCO frame
// pattern with single bit-slips, then enables capture and watches for lock
// loss, re-aligning from channel 0 when any channel drops out.
module adc9252_align_ctrl #(
    parameter int          NCH      = 8,
    parameter int          CH_W     = 3,
    parameter logic [13:0] PATTERN  = 14'h3F80,
    parameter int          SETTLE   = 4,
    parameter int          MAX_SLIP = 14,
    parameter int          STABLE   = 16
) (
    input  logic                 ad_dco_fc,
    input  logic                 reset,
    adc9252_align_ctrl_if.slave  bus
);
    localparam int SLIP_W = $clog2(MAX_SLIP + 1);
    localparam int STAB_W = $clog2(STABLE + 1);
    localparam int SET_W  = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_SLIP   = 3'd2,
        S_SETTLE = 3'd3,
        S_NEXT   = 3'd4,
        S_RUN    = 3'd5,
        S_FAIL   = 3'd6
    } state_t;

    state_t             state, state_nx;
    logic [CH_W-1:0]    ch_idx;
    logic [SLIP_W-1:0]  slip_cnt;
    logic [STAB_W-1:0]  stable_cnt;
    logic [SET_W-1:0]   settle_cnt;
    logic [NCH-1:0]     mm_flag;      // channel mismatched on the previous RUN sample
    logic [NCH-1:0]     ch_aligned;
    logic [7:0]         relock_cnt;

    logic [NCH-1:0]     match;
    logic               cur_match;
    logic               lock_loss;

    // Output registers and their next values
    logic [NCH-1:0]     bit_slip_q, bit_slip_nx;
    logic               capture_en_q, capture_en_nx;
    logic               busy_q, busy_nx;
    logic               done_q, done_nx;
    logic               error_q, error_nx;
    logic [CH_W-1:0]    fail_ch_q, fail_ch_nx;
    logic [2:0]         state_dbg_q, state_dbg_nx;

    // Per-channel frame compare and lock-loss detect
    always_comb begin
        match = '0;
        for (int k = 0; k < NCH; k++)
            match[k] = (bus.frame_word[14*k +: 14] == PATTERN);
        cur_match = match[ch_idx];
        lock_loss = (state == S_RUN) && bus.clk_en && |(~match & mm_flag);
    end

    // State register
    always_ff @(posedge ad_dco_fc) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state decode; only IDLE/FAIL start and NEXT ignore clk_en
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (bus.start) state_nx = S_CHECK;
            S_CHECK:  if (bus.clk_en) begin
                          if (cur_match) begin
                              if (stable_cnt == STAB_W'(STABLE - 1)) state_nx = S_NEXT;
                          end else if (slip_cnt == SLIP_W'(MAX_SLIP)) begin
                              state_nx = S_FAIL;
                          end else begin
                              state_nx = S_SLIP;
                          end
                      end
            S_SLIP:   if (bus.clk_en) state_nx = S_SETTLE;
            S_SETTLE: if (bus.clk_en && settle_cnt == SET_W'(SETTLE - 1)) state_nx = S_CHECK;
            S_NEXT:   state_nx = (ch_idx == CH_W'(NCH - 1)) ? S_RUN : S_CHECK;
            S_RUN:    if (lock_loss) state_nx = S_CHECK;
            S_FAIL:   if (bus.start) state_nx = S_CHECK;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Channel index, slip/stable/settle counters, aligned flags, relock count
    always_ff @(posedge ad_dco_fc) begin
        if (reset) begin
            ch_idx     <= '0;
            slip_cnt   <= '0;
            stable_cnt <= '0;
            settle_cnt <= '0;
            mm_flag    <= '0;
            ch_aligned <= '0;
            relock_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_FAIL: if (bus.start) begin
                    ch_idx     <= '0;
                    slip_cnt   <= '0;
                    stable_cnt <= '0;
                    ch_aligned <= '0;
                end
                S_CHECK: if (bus.clk_en) begin
                    if (!cur_match) begin
                        stable_cnt <= '0;
                    end else if (stable_cnt == STAB_W'(STABLE - 1)) begin
                        stable_cnt         <= '0;
                        ch_aligned[ch_idx] <= 1'b1;
                    end else begin
                        stable_cnt <= stable_cnt + STAB_W'(1);
                    end
                end
                // CHECK routes to FAIL at MAX_SLIP, so this never wraps
                S_SLIP: if (bus.clk_en) begin
                    slip_cnt   <= slip_cnt + SLIP_W'(1);
                    settle_cnt <= '0;
                end
                S_SETTLE: if (bus.clk_en) begin
                    if (settle_cnt == SET_W'(SETTLE - 1)) begin
                        settle_cnt <= '0;
                        stable_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                S_NEXT: begin
                    mm_flag <= '0;
                    if (ch_idx != CH_W'(NCH - 1)) begin
                        ch_idx     <= ch_idx + CH_W'(1);
                        slip_cnt   <= '0;
                        stable_cnt <= '0;
                    end
                end
                S_RUN: if (bus.clk_en) begin
                    if (lock_loss) begin
                        ch_aligned <= '0;
                        mm_flag    <= '0;
                        ch_idx     <= '0;
                        slip_cnt   <= '0;
                        stable_cnt <= '0;
                        if (relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
                    end else begin
                        mm_flag <= ~match;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from the next state so registered outputs track the state
    always_comb begin
        bit_slip_nx = '0;
        if (state == S_SLIP && bus.clk_en) bit_slip_nx[ch_idx] = 1'b1;
        busy_nx       = (state_nx == S_CHECK) || (state_nx == S_SLIP) ||
                        (state_nx == S_SETTLE) || (state_nx == S_NEXT);
        done_nx       = (state_nx == S_RUN);
        capture_en_nx = (state_nx == S_RUN);
        error_nx      = (state_nx == S_FAIL);
        fail_ch_nx    = (state_nx == S_FAIL) ? ch_idx : '0;
        state_dbg_nx  = state_nx;
    end

    // Output registers
    always_ff @(posedge ad_dco_fc) begin
        if (reset) begin
            bit_slip_q   <= '0;
            capture_en_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            fail_ch_q    <= '0;
            state_dbg_q  <= '0;
        end else begin
            bit_slip_q   <= bit_slip_nx;
            capture_en_q <= capture_en_nx;
            busy_q       <= busy_nx;
            done_q       <= done_nx;
            error_q      <= error_nx;
            fail_ch_q    <= fail_ch_nx;
            state_dbg_q  <= state_dbg_nx;
        end
    end

    assign bus.bit_slip   = bit_slip_q;
    assign bus.ch_aligned = ch_aligned;
    assign bus.capture_en = capture_en_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.fail_ch    = fail_ch_q;
    assign bus.relock_cnt = relock_cnt;
    assign bus.state_dbg  = state_dbg_q;
endmodule

// File: tb/tb_adc9252_align_ctrl.sv
// Bench for adc9252_align_ctrl. Each channel is modelled as a deserializer
// whose frame word is PATTERN rotated by an offset; every observed bit_slip
// pulse removes one step of rotation. Expected slip counts, latencies and
// status come from that channel model and the sequencing rules.
module tb_adc9252_align_ctrl;
    localparam logic [13:0] PAT = 14'h3F80;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    adc9252_align_ctrl_if #(.NCH(8), .CH_W(3)) bus ();

    adc9252_align_ctrl dut (
        .ad_dco_fc (clk),
        .reset     (reset),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mode  = 0;          // clk_en: 0 always, 1 random, 2 one in four
    int r[8];               // rotation offset per channel
    int r0[8];
    int slips[8];
    int corrupt_n[8];       // clk_en samples still to corrupt
    bit force_bad[8];       // channel word never matches
    logic [7:0] prev_slip = '0;
    int en_since = 99;
    int last_ch  = -1;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic drive();
        logic [27:0] two;
        logic [13:0] w;
        two = {PAT, PAT};
        for (int k = 0; k < 8; k++) begin
            w = two[r[k] +: 14];
            if (force_bad[k])          w = '0;
            else if (corrupt_n[k] > 0) w = ~w;
            bus.frame_word[14*k +: 14] = w;
        end
    endtask

    task automatic step();
        logic [7:0] obs;
        @(posedge clk); #1;
        cyc++;
        if (bus.clk_en) begin
            en_since++;
            for (int k = 0; k < 8; k++) if (corrupt_n[k] > 0) corrupt_n[k]--;
        end
        obs = bus.bit_slip;
        chk("slip_onehot", 32'($countones(obs) <= 1), 32'd1);
        chk("slip_width", 32'(obs & prev_slip), 32'd0);
        chk("aligned_order", 32'(bus.ch_aligned & (bus.ch_aligned + 8'd1)), 32'd0);
        for (int k = 0; k < 8; k++) begin
            if (obs[k]) begin
                if (k == last_ch) chk("slip_spacing", 32'(en_since >= 4), 32'd1);
                last_ch  = k;
                en_since = 0;
                slips[k]++;
                if (!force_bad[k]) r[k] = (r[k] + 13) % 14;
            end
        end
        prev_slip = obs;
        case (mode)
            1:       bus.clk_en = ($urandom_range(0, 2) != 0);
            2:       bus.clk_en = (cyc % 4 == 0);
            default: bus.clk_en = 1'b1;
        endcase
        drive();
    endtask

    task automatic do_start();
        for (int k = 0; k < 8; k++) slips[k] = 0;
        en_since  = 99;
        last_ch   = -1;
        bus.start = 1'b1;
        bus.clk_en = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            r[k] = 0; force_bad[k] = 0; corrupt_n[k] = 0; slips[k] = 0;
        end
        drive();
    endtask

    // Step until done or error, bounded by max cycles
    task automatic wait_end(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.done && !bus.error && n < max);
    endtask

    int n;
    int cnt;

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.clk_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            r[k] = 0; force_bad[k] = 0; corrupt_n[k] = 0; slips[k] = 0;
        end
        drive();
        repeat (3) step();
        chk("rst_state", 32'(bus.state_dbg), 32'd0);
        chk("rst_outs", 32'({bus.busy, bus.done, bus.error, bus.capture_en, bus.fail_ch}), 32'd0);
        chk("rst_vecs", 32'({bus.bit_slip, bus.ch_aligned, bus.relock_cnt}), 32'd0);
        reset = 1'b0;
        step();

        // All channels already aligned
        mode = 0;
        do_start();
        chk("s1_busy", 32'(bus.busy), 32'd1);
        chk("s1_state", 32'(bus.state_dbg), 32'd1);
        wait_end(2000, n);
        chk("s1_latency", 32'(n), 32'd136);
        chk("s1_done", 32'({bus.done, bus.capture_en, bus.busy}), 32'b110);
        chk("s1_aligned", 32'(bus.ch_aligned), 32'hFF);
        chk("s1_relock", 32'(bus.relock_cnt), 32'd0);
        chk("s1_slips", 32'(slips.sum()), 32'd0);

        // Channel 3 five slips away from aligned
        do_reset();
        r[3] = 5;
        drive();
        do_start();
        wait_end(3000, n);
        chk("s2_latency", 32'(n), 32'd166);
        chk("s2_slips3", 32'(slips[3]), 32'd5);
        chk("s2_slips_all", 32'(slips.sum()), 32'd5);
        chk("s2_done", 32'(bus.done), 32'd1);

        // Channel 6 never matches, random clk_en
        do_reset();
        force_bad[6] = 1;
        mode = 1;
        drive();
        do_start();
        wait_end(10000, n);
        chk("s3_error", 32'({bus.error, bus.done, bus.capture_en}), 32'b100);
        chk("s3_fail_ch", 32'(bus.fail_ch), 32'd6);
        chk("s3_aligned", 32'(bus.ch_aligned), 32'h3F);
        chk("s3_slips6", 32'(slips[6]), 32'd14);
        force_bad[6] = 0;
        r[6] = 0;
        mode = 0;
        drive();
        do_start();
        chk("s3_restart_state", 32'(bus.state_dbg), 32'd1);
        chk("s3_restart_flags", 32'({bus.ch_aligned, bus.error}), 32'd0);
        wait_end(2000, n);
        chk("s3_restart_done", 32'(bus.done), 32'd1);
        chk("s3_relock", 32'(bus.relock_cnt), 32'd0);

        // Random offsets on every channel with random clk_en
        do_reset();
        for (int k = 0; k < 8; k++) begin
            r[k]  = $urandom_range(0, 13);
            r0[k] = r[k];
        end
        mode = 1;
        drive();
        do_start();
        wait_end(20000, n);
        chk("rnd_done", 32'(bus.done), 32'd1);
        for (int k = 0; k < 8; k++) chk("rnd_slips", 32'(slips[k]), 32'(r0[k]));

        // Lock-loss filtering in RUN
        mode = 0;
        corrupt_n[5] = 1;
        drive();
        repeat (5) step();
        chk("run_single", 32'({bus.done, bus.capture_en, bus.state_dbg}), 32'({2'b11, 3'd5}));
        corrupt_n[5] = 1;
        drive();
        step();
        step();
        corrupt_n[5] = 1;
        drive();
        repeat (3) step();
        chk("run_alternate", 32'({bus.capture_en, bus.relock_cnt}), 32'h100);
        corrupt_n[5] = 2;
        drive();
        step();
        chk("run_first_bad", 32'(bus.capture_en), 32'd1);
        step();
        chk("run_loss_cap", 32'({bus.capture_en, bus.done}), 32'd0);
        chk("run_loss_relock", 32'(bus.relock_cnt), 32'd1);
        chk("run_loss_state", 32'({bus.state_dbg, bus.ch_aligned}), 32'({3'd1, 8'h00}));
        wait_end(2000, n);
        chk("run_relock_latency", 32'(n), 32'd136);
        chk("run_relock_done", 32'(bus.done), 32'd1);

        // SETTLE duration with sparse clk_en, then reset mid-SETTLE
        do_reset();
        r[2] = 2;
        mode = 2;
        drive();
        do_start();
        n = 0;
        while (bus.state_dbg != 3'd3 && n < 5000) begin step(); n++; end
        cnt = 1;
        step();
        while (bus.state_dbg == 3'd3 && cnt < 100) begin cnt++; step(); end
        chk("settle_len", 32'(cnt), 32'd16);
        n = 0;
        while (bus.state_dbg != 3'd3 && n < 5000) begin step(); n++; end
        chk("settle2_reached", 32'(bus.state_dbg), 32'd3);
        step();
        step();
        reset = 1'b1;
        step();
        chk("midrst_state", 32'(bus.state_dbg), 32'd0);
        chk("midrst_outs", 32'({bus.busy, bus.done, bus.error, bus.capture_en, bus.fail_ch}), 32'd0);
        chk("midrst_vecs", 32'({bus.bit_slip, bus.ch_aligned, bus.relock_cnt}), 32'd0);
        reset = 1'b0;
        mode = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("idle_quiet", 32'({bus.state_dbg, bus.bit_slip}), 32'd0);
        end
        chk("settle_slips", 32'(slips[2]), 32'd2);

        // relock_cnt saturation
        do_reset();
        mode = 0;
        do_start();
        wait_end(2000, n);
        for (int i = 1; i <= 256; i++) begin
            corrupt_n[0] = 2;
            drive();
            step();
            step();
            chk("sat_relock", 32'(bus.relock_cnt), 32'((i > 255) ? 255 : i));
            wait_end(300, n);
            chk("sat_done", 32'(bus.done), 32'd1);
        end
        chk("sat_final", 32'(bus.relock_cnt), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
